// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver on a 16x oversample tick; even parity bit added when PARITY_EN is defined.
// rx_valid/frame_err/parity_err pulse one clk after the mid-stop-bit tick; no backpressure.
module uart_rx_oversampled #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t               state, state_nxt;
  logic                 rx_meta, rx_s;
  logic [1:0]           flush;
  logic                 armed;
  logic [CW-1:0]        sample_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick_mid, tick_end, last_bit;
  logic                 clr_cnt, shift_en, stop_smp;
  logic                 par_bad;

  // armed only goes high once the synchroniser carries real line samples, so a
  // line held low through reset release is not mistaken for a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      flush   <= 2'b00;
      armed   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      flush   <= {flush[0], 1'b1};
      if (flush[1] && rx_s) armed <= 1'b1;
    end
  end

  assign tick_mid = tick && (sample_cnt == CW'(OVERSAMPLE/2 - 1));
  assign tick_end = tick && (sample_cnt == CW'(OVERSAMPLE - 1));
  assign last_bit = (bit_cnt == BW'(DATA_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (armed && !rx_s) state_nxt = START;
      START:  if (tick_mid) state_nxt = rx_s ? IDLE : DATA;
      DATA:   if (tick_end && last_bit) begin
`ifdef PARITY_EN
        state_nxt = PARITY;
`else
        state_nxt = STOP;
`endif
      end
      PARITY: if (tick_end) state_nxt = STOP;
      STOP:   if (tick_end) state_nxt = rx_s ? IDLE : BREAK;
      BREAK:  if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clr_cnt  = 1'b0;
    shift_en = 1'b0;
    stop_smp = 1'b0;
    case (state)
      IDLE:    clr_cnt  = 1'b1;
      START:   clr_cnt  = tick_mid;
      DATA:    shift_en = tick_end;
      STOP:    stop_smp = tick_end;
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (clr_cnt)
        sample_cnt <= '0;
      else if (tick)
        sample_cnt <= (sample_cnt == CW'(OVERSAMPLE - 1)) ? '0 : sample_cnt + CW'(1);
      if (clr_cnt)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + BW'(1);
      // LSB arrives first, so shifting in at the MSB leaves bit 0 in place
      if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (stop_smp) begin
        if (!rx_s)
          frame_err <= 1'b1;
        else if (!par_bad) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end
      end
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= stop_smp && rx_s && par_bad;
      if (state == PARITY && tick_end) par_bad <= (^shreg) ^ rx_s;
    end
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: tick every 4 clks, one bit = 64 clks.
module tb_uart_rx_oversampled;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, busy;

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int tcnt = 0;
  always @(negedge clk) begin
    tick = (tcnt == 3);
    tcnt = (tcnt + 1) % 4;
  end

  typedef struct {
    int         kind;  // 0 = byte, 1 = frame error, 2 = parity error
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_valid_cyc = 0;
  logic prev_valid = 1'b0;
  int   obs_kind;
  exp_t e;

  always @(negedge clk) begin
    cyc++;
    if (rx_valid || frame_err || parity_err) begin
      obs_kind = rx_valid ? 0 : (frame_err ? 1 : 2);
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got kind=%0d data=%h, required no output", obs_kind, rx_data);
      end else begin
        e = q.pop_front();
        if (obs_kind !== e.kind || (obs_kind == 0 && rx_data !== e.data)) begin
          bad++;
          $display("FAIL scoreboard: got kind=%0d data=%h, required kind=%0d data=%h",
                   obs_kind, rx_data, e.kind, e.data);
        end
      end
      if (rx_valid) last_valid_cyc = cyc;
    end
    if (rx_valid && prev_valid) begin
      total++;
      bad++;
      $display("FAIL valid_width: rx_valid high 2 clks, required 1");
    end
    prev_valid = rx_valid;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clks(64);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef PARITY_EN
    send_bit(par_b);
`else
    if (par_b === 1'bx) rx = 1'b1;
`endif
    send_bit(stop_b);
  endtask

  task automatic push(input int kind, input logic [7:0] d);
    exp_t x;
    x.kind = kind;
    x.data = d;
    q.push_back(x);
  endtask

  task automatic check_drained(input string name);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expected events outstanding, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic check_outputs_zero(input string name);
    total++;
    if ({rx_data, rx_valid, frame_err, parity_err, busy} !== 12'h000) begin
      bad++;
      $display("FAIL %s: data=%h valid=%b ferr=%b perr=%b busy=%b, required all 0",
               name, rx_data, rx_valid, frame_err, parity_err, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    wait_clks(3);
    check_outputs_zero("reset_values");
    rst_n = 1'b1;
    wait_clks(10);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_basic();
    int c0;
    c0 = cyc;
    push(0, 8'hA5);
    send_frame(8'hA5, 1'b1, ^8'hA5);
    wait_clks(10);
    check_drained("basic_drained");
    total++;
    if (last_valid_cyc - c0 < 600 || last_valid_cyc - c0 > 630) begin
      bad++;
      $display("FAIL basic_latency: got %0d clks, required 600..630", last_valid_cyc - c0);
    end
    total++;
    if (rx_data !== 8'hA5 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_hold: data=%h busy=%b, required A5 and 0", rx_data, busy);
    end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    wait_clks(8);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL glitch_busy: busy=%b, required 1", busy);
    end
    wait_clks(8);
    rx = 1'b1;
    wait_clks(64);
    total++;
    if (busy !== 1'b0 || rx_data !== 8'hA5) begin
      bad++;
      $display("FAIL glitch_idle: busy=%b data=%h, required 0 and A5", busy, rx_data);
    end
    check_drained("glitch_no_output");
  endtask

  task automatic test_frame_err();
    push(1, 8'h00);
    send_frame(8'h3C, 1'b0, ^8'h3C);
    wait_clks(200);
    total++;
    if (busy !== 1'b1 || rx_data !== 8'hA5) begin
      bad++;
      $display("FAIL break_hold: busy=%b data=%h, required 1 and A5", busy, rx_data);
    end
    rx = 1'b1;
    wait_clks(5);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL break_exit: busy=%b, required 0", busy);
    end
    check_drained("frame_err_drained");
  endtask

  task automatic test_back_to_back();
    push(0, 8'h00);
    push(0, 8'hFF);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_clks(10);
    check_drained("b2b_drained");
    total++;
    if (rx_data !== 8'hFF) begin
      bad++;
      $display("FAIL b2b_data: got %h, required FF", rx_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    rx = d[3];
    wait_clks(32);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midframe_busy: busy=%b, required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    wait_clks(10);
    rst_n = 1'b1;
    rx    = 1'b1;
    wait_clks(200);
    check_outputs_zero("after_reset_quiet");
    push(0, 8'h81);
    send_frame(8'h81, 1'b1, ^8'h81);
    wait_clks(10);
    check_drained("post_reset_drained");
    total++;
    if (rx_data !== 8'h81) begin
      bad++;
      $display("FAIL post_reset_data: got %h, required 81", rx_data);
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    push(0, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    push(2, 8'h00);
    send_frame(8'h07, 1'b1, 1'b0);
    wait_clks(10);
    check_drained("parity_drained");
    total++;
    if (rx_data !== 8'h07) begin
      bad++;
      $display("FAIL parity_hold: got %h, required 07", rx_data);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
